fifo_stream_reader: RTL
=======================

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of FIFO word and stream data.
REQ-002 SHALL have one clock and an asynchronous, active-high reset.
REQ-003 SHALL have port rclk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rrst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port fifo_empty  input  1  read-side empty flag of the asynchronous FIFO.
REQ-006 SHALL have port fifo_data  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_r_en=1 with fifo_empty=0.
REQ-007 SHALL have port fifo_r_en  output  1  FIFO read request.
REQ-008 SHALL have port m_valid  output  1  stream word available.
REQ-009 SHALL have port m_data  output  DATA_WIDTH  stream word.
REQ-010 SHALL have port m_ready  input  1  downstream accept.
REQ-011 SHALL have port flush  input  1  discard buffered and in-flight words.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL hold a 2-entry in-order buffer; occ = buffered words (0..2), infl = read issued last cycle (0/1).
REQ-014 SHALL drive fifo_r_en = !fifo_empty && !flush && (occ + infl - pop) < 2, where pop = m_valid && m_ready (combinational m_ready-to-fifo_r_en path is intended).
REQ-015 SHALL set infl next cycle only if fifo_r_en=1 and fifo_empty=0 in the current cycle.
REQ-016 SHALL capture fifo_data into the buffer tail on the cycle infl=1, unless that capture is cancelled per REQ-021.
REQ-017 SHALL drive m_valid = (occ != 0) and m_data = head entry; m_data SHALL stay stable while m_valid=1 and m_ready=0.
REQ-018 SHALL leave occ unchanged when capture and pop occur in the same cycle; no word lost, duplicated or reordered.
REQ-019 SHALL sustain one word per cycle with m_ready=1 and FIFO non-empty; first-word latency 2 cycles from fifo_empty falling.
REQ-020 SHALL use states IDLE (occ=0, infl=0), ACTIVE (0 < occ+infl < 2), STALL (occ+infl = 2), FLUSH (one cycle); transitions follow occ+infl each cycle; flush from any state goes to FLUSH, then IDLE.
REQ-021 SHALL, on flush=1: clear occ, force m_valid=0 next cycle, suppress fifo_r_en that cycle, and discard any fifo_data returning the following cycle.
REQ-022 SHALL never issue fifo_r_en while fifo_empty=1; an occ+infl overflow SHALL never occur.

Reset
REQ-023 SHALL, on rrst assertion, immediately clear state to IDLE, occ=0, infl=0, fifo_r_en=0, m_valid=0, m_data=0, busy=0.
REQ-024 SHALL drop an in-flight read on reset mid-operation; the first read after rrst deassertion occurs no earlier than the second rising edge.

Configuration
REQ-025 SHALL, with FIFO_RD_STATS_EN defined, add output rd_count (32 bits: words delivered via pop, wraps at 2^32, reset 0, cleared by flush) and output flush_drop (8 bits: saturating count of words discarded by flush, reset 0).
REQ-026 SHALL, without FIFO_RD_STATS_EN, omit both ports and all associated logic; remaining behaviour is identical.

Structure
REQ-027 SHALL place the state enum (IDLE, ACTIVE, STALL, FLUSH) and the occupancy-count width constant in shared package fifo_pkg.
REQ-028 SHALL implement the 2-entry buffer as sub-module fifo_skid_buf (push, pop, flush, head data, occ).

Verification
REQ-029 Reset: rrst=1 with fifo_empty=0 -> fifo_r_en=0, m_valid=0, m_data=0, busy=0; first fifo_r_en on cycle 2 after release.
REQ-030 Streaming: FIFO holds 0x1..0x8, m_ready=1 -> m_data 0x1..0x8 on 8 consecutive cycles, fifo_r_en held 8 cycles.
REQ-031 Backpressure: m_ready=0 after 0xA loaded -> fifo_r_en stops after 2 issued, state STALL, m_data=0xA stable; m_ready=1 -> 0xA, 0xB delivered in order.
REQ-032 Simultaneous: occ=1, capture and pop in the same cycle -> occ remains 1, output order preserved.
REQ-033 Flush mid-read: flush during cycle with infl=1 -> returning word dropped, m_valid=0 next cycle, state FLUSH then IDLE; flush_drop increments by 2 (stats build).
REQ-034 Stats wrap: preload rd_count=0xFFFFFFFF via 2^32-1 pops (or force) -> one more pop gives 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO stream reader: controller state encoding and
// occupancy-count widths used by the reader and its skid buffer.
package fifo_pkg;

  localparam int OCC_W  = 2;          // holds buffered-word count 0..2
  localparam int PEND_W = OCC_W + 1;  // occ + in-flight read before a pop

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  // Maps words owned by the reader (buffered plus in flight) to a state.
  function automatic state_t state_for(input logic [PEND_W-1:0] pending);
    if (pending == '0) return IDLE;
    if (pending >= PEND_W'(2)) return STALL;
    return ACTIVE;
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order buffer between the FIFO read port and the stream output.
// Flush empties it in one cycle; entry contents are left as-is.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [OCC_W-1:0]      occ
);

  logic                      head_reg;
  logic                      tail_reg;
  logic [OCC_W-1:0]          occ_reg;
  logic [1:0][DATA_WIDTH-1:0] entries;

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    logic [DATA_WIDTH-1:0] entry_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        entry_reg <= '0;
      end else if (push && !flush && (tail_reg == 1'(gi))) begin
        entry_reg <= push_data;
      end
    end

    assign entries[gi] = entry_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg <= 1'b0;
      tail_reg <= 1'b0;
      occ_reg  <= '0;
    end else if (flush) begin
      head_reg <= 1'b0;
      tail_reg <= 1'b0;
      occ_reg  <= '0;
    end else begin
      if (push) tail_reg <= ~tail_reg;
      if (pop)  head_reg <= ~head_reg;
      occ_reg <= occ_reg + OCC_W'(push) - OCC_W'(pop);
    end
  end

  assign head_data = entries[head_reg];
  assign occ       = occ_reg;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains an asynchronous FIFO read port into a valid/ready stream at one word
// per cycle. Define FIFO_RD_STATS_EN to add the rd_count/flush_drop counters.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  input  logic                  flush,
`ifdef FIFO_RD_STATS_EN
  output logic [31:0]           rd_count,
  output logic [7:0]            flush_drop,
`endif
  output logic                  busy
);

  state_t            state_reg;
  state_t            state_next;
  logic              infl_reg;
  logic [1:0]        rst_done_reg;
  logic [OCC_W-1:0]  occ;
  logic [PEND_W-1:0] pending;
  logic              has_word;
  logic              pop;
  logic              push;
  logic              accept;
  logic              rd_ok;

  assign has_word = (occ != '0);
  assign pop      = has_word && m_ready;
  // A word returning in a flush cycle is dropped rather than captured.
  assign push     = infl_reg && !flush;
  assign pending  = PEND_W'(occ) + PEND_W'(infl_reg) - PEND_W'(pop);
  assign rd_ok    = rst_done_reg[1] && !fifo_empty && (pending < PEND_W'(2));
  assign accept   = fifo_r_en && !fifo_empty;

  fifo_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk       (rclk),
    .rst       (rrst),
    .push      (push),
    .push_data (fifo_data),
    .pop       (pop),
    .flush     (flush),
    .head_data (m_data),
    .occ       (occ)
  );

  // rst_done_reg holds reads off until the second edge after reset release.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_reg    <= IDLE;
      infl_reg     <= 1'b0;
      rst_done_reg <= 2'b00;
    end else begin
      state_reg    <= state_next;
      infl_reg     <= accept;
      rst_done_reg <= {rst_done_reg[0], 1'b1};
    end
  end

  always_comb begin
    state_next = state_for(pending + PEND_W'(accept));
    if (flush) state_next = FLUSH;
  end

  always_comb begin
    fifo_r_en = rd_ok && !flush && (state_reg != FLUSH);
    m_valid   = has_word;
    busy      = (state_reg != IDLE);
  end

`ifdef FIFO_RD_STATS_EN
  logic [31:0] rd_count_reg;
  logic [7:0]  flush_drop_reg;
  logic [8:0]  drop_sum;

  // pending is exactly what a flush throws away: buffered + in flight - popped.
  assign drop_sum = {1'b0, flush_drop_reg} + 9'(pending);

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rd_count_reg   <= '0;
      flush_drop_reg <= '0;
    end else if (flush) begin
      rd_count_reg   <= '0;
      flush_drop_reg <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end else if (pop) begin
      rd_count_reg <= rd_count_reg + 32'd1;
    end
  end

  assign rd_count   = rd_count_reg;
  assign flush_drop = flush_drop_reg;
`endif

endmodule
